// File: rtl/vga_axil_wr_joiner_pkg.sv
// Shared types and width defaults for the VGA AXI-Lite write front end.
package vga_axil_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_e;

  localparam int DEF_AXIL_ADDR_WIDTH = 32;
  localparam int DEF_AXIL_DATA_WIDTH = 32;
endpackage

// File: rtl/vga_axil_wr_joiner_if.sv
// AXI-Lite write slave port plus the joined write-request port, seen from the joiner.
interface vga_axil_wr_joiner_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [AW-1:0] s_axil_awaddr_i;
  logic          s_axil_awvalid_i;
  logic          s_axil_awready_o;
  logic [DW-1:0] s_axil_wdata_i;
  logic [SW-1:0] s_axil_wstrb_i;
  logic          s_axil_wvalid_i;
  logic          s_axil_wready_o;
  logic [1:0]    s_axil_bresp_o;
  logic          s_axil_bvalid_o;
  logic          s_axil_bready_i;
  logic          wr_valid_o;
  logic          wr_ready_i;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [SW-1:0] wr_strb_o;

  modport slave (
    input  s_axil_awaddr_i, s_axil_awvalid_i, s_axil_wdata_i, s_axil_wstrb_i,
           s_axil_wvalid_i, s_axil_bready_i, wr_ready_i,
    output s_axil_awready_o, s_axil_wready_o, s_axil_bresp_o, s_axil_bvalid_o,
           wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );

  modport master (
    output s_axil_awaddr_i, s_axil_awvalid_i, s_axil_wdata_i, s_axil_wstrb_i,
           s_axil_wvalid_i, s_axil_bready_i, wr_ready_i,
    input  s_axil_awready_o, s_axil_wready_o, s_axil_bresp_o, s_axil_bvalid_o,
           wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );
endinterface

// File: rtl/vga_axil_wr_joiner_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
module vga_axil_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [PTR_W:0]   r_cnt, w_cnt_n;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push = push_i && !r_full;
  assign w_pop  = pop_i && !r_empty;

  always_comb begin
    w_cnt_n = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_n = r_cnt + (PTR_W+1)'(1);
      2'b01:   w_cnt_n = r_cnt - (PTR_W+1)'(1);
      default: w_cnt_n = r_cnt;
    endcase
  end

  // full is held high during reset so the upstream ready stays low until release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b1;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      r_cnt   <= w_cnt_n;
      r_full  <= (w_cnt_n == (PTR_W+1)'(DEPTH));
      r_empty <= (w_cnt_n == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= din_i;
  end

  assign dout_o  = r_mem[r_rp];
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign count_o = r_cnt;
endmodule

// File: rtl/vga_axil_wr_joiner.sv
// Buffers AW and W independently, joins them into write requests, answers B in AW order.
module vga_axil_wr_joiner
  import vga_axil_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = DEF_AXIL_ADDR_WIDTH,
  parameter int AXIL_DATA_WIDTH = DEF_AXIL_DATA_WIDTH,
  parameter int FIFO_DEPTH      = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  vga_axil_wr_joiner_if.slave bus
);
  localparam int STRB_W = AXIL_DATA_WIDTH / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]          strb;
  } wbeat_t;

  typedef struct packed {
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]          strb;
  } req_t;

  logic [AXIL_ADDR_WIDTH-1:0] w_aw_head;
  wbeat_t                     w_w_din, w_w_head;
  axil_resp_e                 w_b_din, w_b_head;
  logic                       w_aw_full, w_aw_empty, w_w_full, w_w_empty, w_b_full, w_b_empty;
  logic [CNT_W-1:0]           w_aw_cnt, w_w_cnt, w_b_cnt, w_b_free;
  logic                       w_aw_push, w_w_push, w_join, w_join_ok, w_join_err;
  logic                       w_accept, w_b_push, w_b_pop, w_misalign, w_unused;
  req_t                       r_req;
  logic                       r_wr_valid;

  assign w_aw_push = bus.s_axil_awvalid_i && !w_aw_full;
  assign w_w_push  = bus.s_axil_wvalid_i && !w_w_full;
  assign w_w_din   = '{data: bus.s_axil_wdata_i, strb: bus.s_axil_wstrb_i};

  // a loaded output register already owns one B slot, hence the strict compare
  assign w_misalign = |w_aw_head[OFS_W-1:0];
  assign w_b_free   = CNT_W'(FIFO_DEPTH) - w_b_cnt;
  assign w_accept   = r_wr_valid && bus.wr_ready_i;
  assign w_join     = !w_aw_empty && !w_w_empty
                   && (w_b_free > CNT_W'(r_wr_valid))
                   && (!r_wr_valid || bus.wr_ready_i)
                   && (!w_misalign || !r_wr_valid);
  assign w_join_ok  = w_join && !w_misalign;
  assign w_join_err = w_join && w_misalign;
  assign w_b_push   = w_accept || w_join_err;
  assign w_b_din    = w_join_err ? RESP_SLVERR : RESP_OKAY;
  assign w_b_pop    = !w_b_empty && bus.s_axil_bready_i;
  assign w_unused   = ^{w_aw_cnt, w_w_cnt, w_b_full};

  vga_axil_fifo #(.T(logic [AXIL_ADDR_WIDTH-1:0]), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_aw_push), .din_i(bus.s_axil_awaddr_i),
    .pop_i(w_join), .dout_o(w_aw_head), .full_o(w_aw_full), .empty_o(w_aw_empty),
    .count_o(w_aw_cnt)
  );

  vga_axil_fifo #(.T(wbeat_t), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_w_push), .din_i(w_w_din),
    .pop_i(w_join), .dout_o(w_w_head), .full_o(w_w_full), .empty_o(w_w_empty),
    .count_o(w_w_cnt)
  );

  vga_axil_fifo #(.T(axil_resp_e), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_b_push), .din_i(w_b_din),
    .pop_i(w_b_pop), .dout_o(w_b_head), .full_o(w_b_full), .empty_o(w_b_empty),
    .count_o(w_b_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_valid <= 1'b0;
      r_req      <= '0;
    end else if (w_join_ok) begin
      r_wr_valid <= 1'b1;
      r_req      <= '{addr: w_aw_head, data: w_w_head.data, strb: w_w_head.strb};
    end else if (w_accept) begin
      r_wr_valid <= 1'b0;
    end
  end

  assign bus.s_axil_awready_o = !w_aw_full;
  assign bus.s_axil_wready_o  = !w_w_full;
  assign bus.s_axil_bvalid_o  = !w_b_empty;
  assign bus.s_axil_bresp_o   = w_b_empty ? RESP_OKAY : w_b_head;
  assign bus.wr_valid_o       = r_wr_valid;
  assign bus.wr_addr_o        = r_req.addr;
  assign bus.wr_data_o        = r_req.data;
  assign bus.wr_strb_o        = r_req.strb;
endmodule
